// File: rtl/adder_pipe_pkg.sv
// Shared constants for the pipelined ripple-carry adder: default geometry and
// the per-stage chunk width derivation.
package adder_pipe_pkg;

    localparam int DEFAULT_WIDTH  = 16;
    localparam int DEFAULT_STAGES = 4;

    // Guarded so an illegal STAGES value reaches the elaboration check instead of dividing by zero.
    function automatic int chunk_width(input int width, input int stages);
        return (stages > 0) ? width / stages : width;
    endfunction

endpackage

// File: rtl/adder_pipe_stage.sv
// One CHUNK-bit slice of the carry chain: adds its operand chunk plus the
// incoming carry and registers partial sum, carry and valid on enable.
module adder_pipe_stage #(
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             valid_in,
    input  logic             carry_in,
    input  logic [CHUNK-1:0] a_chunk,
    input  logic [CHUNK-1:0] b_chunk,
    output logic [CHUNK-1:0] sum_q,
    output logic             carry_q,
    output logic             valid_q
);

    logic [CHUNK:0] total;

    assign total = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_in};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q   <= '0;
            carry_q <= 1'b0;
            valid_q <= 1'b0;
        end else if (en) begin
            {carry_q, sum_q} <= total;
            valid_q          <= valid_in;
        end
    end

endmodule

// File: rtl/adder_pipe.sv
// Pipelined ripple-carry adder, one register stage per CHUNK-bit carry chunk.
// Optional macro ADDER_PIPE_OVF_EN adds the signed-overflow output ovf.
module adder_pipe
    import adder_pipe_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int STAGES = DEFAULT_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef ADDER_PIPE_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CHUNK = chunk_width(WIDTH, STAGES);

    if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_params
        $error("adder_pipe: WIDTH must be a multiple of STAGES and STAGES must be in 1..WIDTH");
    end

    // The whole pipeline moves as one; bubbles are never squeezed out during a stall.
    logic adv;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    for (genvar k = 0; k < STAGES; k++) begin : stg
        localparam int REM = WIDTH - k * CHUNK;

        logic [REM-1:0]         a_in;
        logic [REM-1:0]         b_in;
        logic                   carry_in;
        logic                   valid_in;
        logic [CHUNK-1:0]       chunk_sum;
        logic                   carry;
        logic                   valid;
        logic [(k+1)*CHUNK-1:0] sum_acc;

        if (k == 0) begin : g_first
            assign a_in     = a;
            assign b_in     = b;
            assign carry_in = cin;
            assign valid_in = in_valid;
            assign sum_acc  = chunk_sum;
        end else begin : g_next
            logic [k*CHUNK-1:0] lo_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    lo_q <= '0;
                end else if (adv) begin
                    lo_q <= stg[k-1].sum_acc;
                end
            end

            assign a_in     = stg[k-1].g_fwd.a_rem;
            assign b_in     = stg[k-1].g_fwd.b_rem;
            assign carry_in = stg[k-1].carry;
            assign valid_in = stg[k-1].valid;
            assign sum_acc  = {chunk_sum, lo_q};
        end

        // Only the operand chunks still waiting to be added travel forward.
        if (k < STAGES - 1) begin : g_fwd
            logic [REM-CHUNK-1:0] a_rem;
            logic [REM-CHUNK-1:0] b_rem;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_rem <= '0;
                    b_rem <= '0;
                end else if (adv) begin
                    a_rem <= a_in[REM-1:CHUNK];
                    b_rem <= b_in[REM-1:CHUNK];
                end
            end
        end

        adder_pipe_stage #(
            .CHUNK(CHUNK)
        ) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .en      (adv),
            .valid_in(valid_in),
            .carry_in(carry_in),
            .a_chunk (a_in[CHUNK-1:0]),
            .b_chunk (b_in[CHUNK-1:0]),
            .sum_q   (chunk_sum),
            .carry_q (carry),
            .valid_q (valid)
        );
    end

    assign sum       = stg[STAGES-1].sum_acc;
    assign cout      = stg[STAGES-1].carry;
    assign out_valid = stg[STAGES-1].valid;

`ifdef ADDER_PIPE_OVF_EN
    // Operand MSBs are captured with the final chunk so ovf lines up with sum.
    logic a_msb_q;
    logic b_msb_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
        end else if (adv) begin
            a_msb_q <= stg[STAGES-1].a_in[CHUNK-1];
            b_msb_q <= stg[STAGES-1].b_in[CHUNK-1];
        end
    end

    assign ovf = (a_msb_q == b_msb_q) && (sum[WIDTH-1] != a_msb_q);
`endif

endmodule

// File: tb/tb_adder_pipe.sv
// Directed self-checking bench for adder_pipe at WIDTH=16, STAGES=4.
module tb_adder_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
`ifdef ADDER_PIPE_OVF_EN
    logic        ovf;
`endif

    int tests_run;
    int tests_failed;

    adder_pipe #(
        .WIDTH (16),
        .STAGES(4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .cout     (cout)
`ifdef ADDER_PIPE_OVF_EN
        ,
        .ovf      (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b0 || sum !== 16'h0000 || cout !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_state: out_valid=%b sum=%h cout=%b, expected 0/0000/0",
                     out_valid, sum, cout);
        end
        rst_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_release: in_ready=%b out_valid=%b, expected 1/0",
                     in_ready, out_valid);
        end
    endtask

    task automatic test_single_op(input string name, input logic [15:0] op_a,
                                  input logic [15:0] op_b, input logic op_cin,
                                  input logic [15:0] exp_sum, input logic exp_cout);
        drain();
        in_valid = 1'b1;
        a        = op_a;
        b        = op_b;
        cin      = op_cin;
        @(negedge clk);
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        cin      = 1'b0;
        for (int c = 1; c < 4; c++) begin
            tests_run++;
            if (out_valid !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL %s_early: out_valid=%b after %0d cycles, expected 0",
                         name, out_valid, c);
            end
            @(negedge clk);
        end
        tests_run++;
        if (out_valid !== 1'b1 || sum !== exp_sum || cout !== exp_cout) begin
            tests_failed++;
            $display("[TB] FAIL %s: out_valid=%b sum=%h cout=%b, expected 1/%h/%b",
                     name, out_valid, sum, cout, exp_sum, exp_cout);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_tbl [8];
        exp_tbl = '{16'd0, 16'd5, 16'd8, 16'd13, 16'd16, 16'd21, 16'd24, 16'd29};
        drain();
        for (int c = 0; c < 13; c++) begin
            @(negedge clk);
            tests_run++;
            if (out_valid !== ((c >= 4 && c < 12) ? 1'b1 : 1'b0) || in_ready !== 1'b1) begin
                tests_failed++;
                $display("[TB] FAIL stream_valid: cycle %0d out_valid=%b in_ready=%b", c,
                         out_valid, in_ready);
            end
            if (c >= 4 && c < 12) begin
                tests_run++;
                if (sum !== exp_tbl[c-4] || cout !== 1'b0) begin
                    tests_failed++;
                    $display("[TB] FAIL stream_data: result %0d sum=%h cout=%b, expected %h/0",
                             c - 4, sum, cout, exp_tbl[c-4]);
                end
            end
            in_valid = (c < 8);
            a        = 16'(c);
            b        = 16'(c * 3);
            cin      = c[0];
        end
        in_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        int sent;
        int recv;
        int stall_checks;
        sent         = 0;
        recv         = 0;
        stall_checks = 0;
        drain();
        for (int c = 0; c < 40 && recv < 8; c++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                tests_run++;
                if (sum !== 16'(recv) || cout !== 1'b1) begin
                    tests_failed++;
                    $display("[TB] FAIL bp_data: result %0d sum=%h cout=%b, expected %h/1",
                             recv, sum, cout, 16'(recv));
                end
            end
            out_ready = !(c >= 5 && c <= 9);
            in_valid  = (sent < 8);
            a         = 16'hFFF0 + 16'(sent);
            b         = 16'h0010;
            cin       = 1'b0;
            #1;
            if (out_valid === 1'b1 && out_ready == 1'b0) begin
                stall_checks++;
                tests_run++;
                if (in_ready !== 1'b0) begin
                    tests_failed++;
                    $display("[TB] FAIL bp_in_ready: cycle %0d in_ready=%b, expected 0", c,
                             in_ready);
                end
            end
            if (in_valid && in_ready === 1'b1) sent++;
            if (out_valid === 1'b1 && out_ready) recv++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tests_run++;
        if (sent != 8 || recv != 8 || stall_checks != 5) begin
            tests_failed++;
            $display("[TB] FAIL bp_counts: sent=%0d recv=%0d stalls=%0d, expected 8/8/5", sent,
                     recv, stall_checks);
        end
    endtask

    task automatic test_reset_midflight();
        int stale;
        stale = 0;
        drain();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            in_valid = 1'b1;
            a        = 16'(c + 1);
            b        = 16'h0001;
            cin      = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b0;
        tests_run++;
        if (out_valid !== 1'b1 || sum !== 16'h0002) begin
            tests_failed++;
            $display("[TB] FAIL midflight_prefill: out_valid=%b sum=%h, expected 1/0002",
                     out_valid, sum);
        end
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || sum !== 16'h0000 || cout !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL midflight_reset: out_valid=%b sum=%h cout=%b, expected 0/0000/0",
                     out_valid, sum, cout);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) stale++;
        end
        tests_run++;
        if (stale != 0) begin
            tests_failed++;
            $display("[TB] FAIL midflight_stale: %0d cycles with out_valid=1, expected 0", stale);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_single_op("single_op", 16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0);
        test_single_op("carry_ripple", 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1);
        test_single_op("full_overflow", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1);
        test_single_op("chunk_carries", 16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0);
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
